// File: rtl/pw_lock_pkg.sv
// Shared types and helpers for the serial password lock.
package pw_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_ERROR    = 2'd1,
        ST_UNLOCKED = 2'd2
    } lock_state_t;

    localparam int MAX_CODE_W = 256;
    localparam int MAX_DW     = 32;

    // Extracts digit i of a packed code whose digits are dw bits wide.
    function automatic logic [MAX_DW-1:0] admin_digit(input logic [MAX_CODE_W-1:0] code,
                                                      input int i, input int dw);
        logic [MAX_CODE_W-1:0] sh;
        logic [MAX_DW-1:0]     mask;
        sh   = code >> (i * dw);
        mask = (dw >= MAX_DW) ? '1 : ((MAX_DW'(1) << dw) - MAX_DW'(1));
        return sh[MAX_DW-1:0] & mask;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Lockout flag with an optional self-expiring countdown.
module lockout_timer #(
    parameter int LOCK_CYCLES = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic clear,
    output logic active,
    output logic expire
);
    localparam int TW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES);

    logic [TW-1:0] timer;
    logic          locked;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer  <= '0;
            locked <= 1'b0;
        end else if (clear) begin
            timer  <= '0;
            locked <= 1'b0;
        end else if (load) begin
            timer  <= LOAD_VAL;
            locked <= 1'b1;
        end else if (timer != '0) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1))
                locked <= 1'b0;
        end
    end

    // A zero timer never reaches 1, so LOCK_CYCLES=0 holds the lock indefinitely.
    assign expire = locked && (timer == TW'(1));
    assign active = locked;

endmodule

// File: rtl/password_lock_core.sv
// Serial password checker: judges only after the last digit, with admin bypass and timed lockout.
module password_lock_core
    import pw_lock_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] ADMIN_CODE = '0,
    localparam int AW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1,
    localparam int FW = $clog2(MAX_FAILS + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [DIGIT_W-1:0] data,
    input  logic               resetLockDown,
    input  logic               relock,
    output logic [AW-1:0]      address,
    output logic               errorLight,
    output logic               unlockLight,
    output logic               lockDown,
    output logic [FW-1:0]      failCount
);
    localparam logic [AW-1:0] LAST     = AW'(DIGITS - 1);
    localparam logic [FW:0]   FAIL_LIM = (FW+1)'(MAX_FAILS);

    lock_state_t   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          user_ok_q, user_ok_d;
    logic          admin_ok_q, admin_ok_d;
    logic [FW-1:0] fail_q, fail_d;

    logic t_load, t_clear, locked, expire;
    logic eff_locked, user_hit, admin_hit;
    logic [FW-1:0]      fail_base;
    logic [FW:0]        fail_inc;
    logic [MAX_DW-1:0]  adm_full;
    logic [DIGIT_W-1:0] adm_dig;

    lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (t_load),
        .clear  (t_clear),
        .active (locked),
        .expire (expire)
    );

    assign adm_full  = admin_digit(MAX_CODE_W'(ADMIN_CODE), int'(idx_q), DIGIT_W);
    assign adm_dig   = adm_full[DIGIT_W-1:0];
    assign user_hit  = user_ok_q && (digit == data);
    assign admin_hit = admin_ok_q && (digit == adm_dig);

    // Expiry on this edge is applied before the entry is judged.
    assign eff_locked = locked && !expire;
    assign fail_base  = expire ? '0 : fail_q;
    assign fail_inc   = {1'b0, fail_base} + (FW+1)'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        user_ok_d  = user_ok_q;
        admin_ok_d = admin_ok_q;
        fail_d     = fail_base;
        t_load     = 1'b0;
        t_clear    = 1'b0;
        if (resetLockDown) begin
            state_d    = ST_ENTRY;
            idx_d      = '0;
            user_ok_d  = 1'b1;
            admin_ok_d = 1'b1;
            fail_d     = '0;
            t_clear    = 1'b1;
        end else if (relock && state_q == ST_UNLOCKED) begin
            state_d    = ST_ENTRY;
            idx_d      = '0;
            user_ok_d  = 1'b1;
            admin_ok_d = 1'b1;
        end else if (enable && state_q != ST_UNLOCKED) begin
            state_d = ST_ENTRY;
            if (idx_q == LAST) begin
                idx_d      = '0;
                user_ok_d  = 1'b1;
                admin_ok_d = 1'b1;
                if (admin_hit) begin
                    state_d = ST_UNLOCKED;
                    fail_d  = '0;
                    t_clear = 1'b1;
                end else if (user_hit && !eff_locked) begin
                    state_d = ST_UNLOCKED;
                    fail_d  = '0;
                end else begin
                    state_d = ST_ERROR;
                    if (!eff_locked) begin
                        if (fail_inc >= FAIL_LIM) begin
                            fail_d = FAIL_LIM[FW-1:0];
                            t_load = 1'b1;
                        end else begin
                            fail_d = fail_inc[FW-1:0];
                        end
                    end
                end
            end else begin
                idx_d      = idx_q + AW'(1);
                user_ok_d  = user_hit;
                admin_ok_d = admin_hit;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_ENTRY;
            idx_q      <= '0;
            user_ok_q  <= 1'b1;
            admin_ok_q <= 1'b1;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            user_ok_q  <= user_ok_d;
            admin_ok_q <= admin_ok_d;
            fail_q     <= fail_d;
        end
    end

    assign address     = (state_q == ST_UNLOCKED) ? '0 : idx_q;
    assign errorLight  = (state_q == ST_ERROR);
    assign unlockLight = (state_q == ST_UNLOCKED);
    assign lockDown    = locked;
    assign failCount   = fail_q;

endmodule

// File: doc/password_lock_core.md
# password_lock_core

Parametrised serial password checker, the successor of the 4-digit validator in the Serial Password Lock design. Accepts one digit per `enable` strobe, reads the stored user password from the external password memory, and judges the entry only after all `DIGITS` digits arrive, so the failing position is never revealed. Adds a compile-time admin code, a configurable failure limit, and a lockout that auto-expires after `LOCK_CYCLES`. Sits between the keypad debouncer and the lights/display logic.

## Interface
- `DIGITS`, 4: digits per password, ≥2.
- `DIGIT_W`, 4: bits per digit.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout, ≥1.
- `LOCK_CYCLES`, 1000: lockout duration in CLK cycles; 0 = no timeout.
- `ADMIN_CODE`, 0: `DIGITS*DIGIT_W` bits; digit i occupies `[i*DIGIT_W +: DIGIT_W]`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `enable` in 1: digit strobe, one cycle per digit.
- `digit` in DIGIT_W: keyed digit, valid when `enable`=1.
- `data` in DIGIT_W: stored digit at `address`, combinational read, same cycle.
- `resetLockDown` in 1: clears lockout and failure count.
- `relock` in 1: leaves the unlocked state.
- `address` out AW=max(1,$clog2(DIGITS)): index of the digit currently expected.
- `errorLight` out 1: last entry wrong.
- `unlockLight` out 1: unlocked.
- `lockDown` out 1: lockout active.
- `failCount` out $clog2(MAX_FAILS+1): consecutive failures.

## Operation
- Registers: `state` ∈ {ENTRY, ERROR, UNLOCKED}; `idx`; `userOk`; `adminOk`; `locked`; `failCount`; `timer`.
- Reset values: state=ENTRY, idx=0, userOk=adminOk=1, locked=0, failCount=0, timer=0. All lights 0. address=0.
- `address` = idx in ENTRY and ERROR; 0 in UNLOCKED.
- ENTRY or ERROR, `enable`=1:
  - userOk &= (digit==data); adminOk &= (digit==ADMIN_CODE slice idx).
  - ERROR moves to ENTRY on this strobe. The digit counts as digit 0.
  - If idx<DIGITS-1, idx increments.
- Final digit (idx=DIGITS-1), with match values including the current digit:
  - Admin match: UNLOCKED, failCount=0, locked=0.
  - User match while not locked: UNLOCKED, failCount=0.
  - Otherwise, if not locked: failCount+1. Reaching MAX_FAILS sets locked=1 and timer=LOCK_CYCLES.
  - Otherwise, if already locked: failCount holds and timer is not restarted.
  - Any failure: state=ERROR.
  - In every case idx=0, userOk=adminOk=1.
- UNLOCKED: `enable` ignored. `relock`=1 gives ENTRY with idx=0.
- Locked: timer decrements each cycle while nonzero. On 1→0: locked=0, failCount=0. With LOCK_CYCLES=0 only admin code or `resetLockDown` clears it.
- `resetLockDown`: locked=0, failCount=0, timer=0, state=ENTRY, idx=0, userOk=adminOk=1. Any `enable` that cycle is discarded.
- Outputs are decoded from registers:
  - errorLight = (state==ERROR).
  - unlockLight = (state==UNLOCKED).
  - lockDown = locked.

## Timing
- Priority: RST > resetLockDown > relock > enable.
- A digit is sampled on the CLK edge where `enable`=1. Lights change at that same edge for the final digit, one cycle latency.
- `data` must settle within the cycle `address` is driven.
- Timer expiry and the final digit in the same cycle: expiry applies first, then the entry is judged as unlocked. A correct user code unlocks.
- RST mid-entry discards the partial entry. RST during lockout clears lockout.
- failCount saturates at MAX_FAILS.

## Structure
- Package `pw_lock_pkg`:
  - `lock_state_t` enum.
  - Helper function `admin_digit(code, i)`.
- Sub-module `lockout_timer`:
  - Inputs: load, clear, `LOCK_CYCLES` parameter.
  - Outputs: active flag, expire pulse.
  - Owns `timer` and `locked`.

## Test plan
All scenarios use DIGITS=4, DIGIT_W=4, MAX_FAILS=3, LOCK_CYCLES=20, ADMIN_CODE=16'h9999, stored password 1,2,3,4.
- Enter 1,2,3,4 → unlockLight=1 at the 4th strobe edge, failCount=0. `relock` → unlockLight=0, address=0.
- Enter 1,9,3,4 → no light until the 4th digit, then errorLight=1, failCount=1. Next strobe clears errorLight.
- Three wrong entries → lockDown=1 at the 3rd final edge. Correct 1,2,3,4 → errorLight, still locked. After 20 cycles lockDown=0, failCount=0.
- While locked, enter 9,9,9,9 → unlockLight=1, lockDown=0.
- Lockout, then `resetLockDown` together with `enable` → lockDown=0, digit discarded, address=0.
- Assert RST after 2 digits → all outputs 0. Then 1,2,3,4 → unlock.
